cr_register_file: RTL and testbench

Condition Register (CR) file with per-field rename tags. It is the receiving end of the CR write-back bus driven by the write-back arbiter. It holds the eight 4-bit CR fields, tracks which reservation-station entry (rs_id) will produce each field, and retires matching write-backs. It also serves dispatch with operand reads that include same-cycle write-back forwarding.

---
 rtl/cr_register_file_pkg.sv | 24 ++
 rtl/cr_register_file_if.sv | 28 ++
 rtl/cr_register_file_cr_field_slot.sv | 60 ++++++
 rtl/cr_register_file.sv | 63 ++++++
 tb/tb_cr_register_file.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/cr_register_file_pkg.sv
// Shared CR-file types: field record, field count and CR image field extraction.
package cr_register_file_pkg;

  localparam int CR_FIELDS      = 8;
  localparam int CR_FIELD_BITS  = 4;
  localparam int CR_IMAGE_BITS  = CR_FIELDS * CR_FIELD_BITS;
  localparam int RS_ID_WIDTH_DEF = 5;

  // One CR field as seen by dispatch and the write-back arbiter.
  typedef struct packed {
    logic [0:CR_FIELD_BITS-1]   value;
    logic                       busy;
    logic [RS_ID_WIDTH_DEF-1:0] tag;
  } cr_field_t;

  // Field i occupies bits [4i:4i+3] of the MSB-first CR image.
  function automatic logic [0:CR_FIELD_BITS-1] cr_field_of(
    input logic [0:CR_IMAGE_BITS-1] img,
    input int unsigned              idx
  );
    return img[CR_FIELD_BITS*idx +: CR_FIELD_BITS];
  endfunction

endpackage

// File: rtl/cr_register_file_if.sv
// CR write-back bus from the write-back arbiter; no ready, accepted every cycle.
interface cr_register_file_if
  import cr_register_file_pkg::*;
#(
  parameter int RS_ID_WIDTH = 5
);

  // Handshake: a beat transfers on every cycle wb_valid is high; the receiver cannot stall.
  logic                                  wb_valid;
  logic [CR_FIELDS-1:0][RS_ID_WIDTH-1:0] wb_rs_id;
  logic [CR_FIELDS-1:0]                  wb_enable;
  logic [0:CR_IMAGE_BITS-1]              wb_result;

  modport master (
    output wb_valid,
    output wb_rs_id,
    output wb_enable,
    output wb_result
  );

  modport slave (
    input wb_valid,
    input wb_rs_id,
    input wb_enable,
    input wb_result
  );

endinterface

// File: rtl/cr_register_file_cr_field_slot.sv
// One CR field: value/busy/tag storage, write-back retire, reservation, flush and forwarding.
module cr_field_slot
  import cr_register_file_pkg::*;
#(
  parameter int RS_ID_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid,
  input  logic                     wb_enable,
  input  logic [RS_ID_WIDTH-1:0]   wb_rs_id,
  input  logic [0:CR_FIELD_BITS-1] wb_field,
  input  logic                     rsv_fire,
  input  logic                     rsv_enable,
  input  logic [RS_ID_WIDTH-1:0]   rsv_rs_id,
  input  logic                     flush,
  output logic [0:CR_FIELD_BITS-1] fwd_value,
  output logic                     fwd_busy,
  output logic [RS_ID_WIDTH-1:0]   fwd_tag
);

  logic [0:CR_FIELD_BITS-1] value_q;
  logic                     busy_q;
  logic [RS_ID_WIDTH-1:0]   tag_q;
  logic                     wb_write;

  // A write lands when the field is idle or the write-back comes from the recorded producer.
  assign wb_write = wb_valid && wb_enable && (!busy_q || (tag_q == wb_rs_id));

  always_comb begin
    fwd_value = value_q;
    fwd_busy  = busy_q;
    if (wb_write) begin
      fwd_value = wb_field;
      fwd_busy  = 1'b0;
    end
    fwd_tag = fwd_busy ? tag_q : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q <= '0;
      busy_q  <= 1'b0;
      tag_q   <= '0;
    end else begin
      if (wb_write) begin
        value_q <= wb_field;
        busy_q  <= 1'b0;
      end
      // Flush and reservation are applied after write-back so they win busy/tag.
      if (flush) begin
        busy_q <= 1'b0;
      end else if (rsv_fire && rsv_enable) begin
        busy_q <= 1'b1;
        tag_q  <= rsv_rs_id;
      end
    end
  end

endmodule

// File: rtl/cr_register_file.sv
// Condition Register file with per-field rename tags, forwarded read ports and full-CR view.
module cr_register_file
  import cr_register_file_pkg::*;
#(
  parameter int RS_ID_WIDTH = 5
) (
  input  logic                                clk,
  input  logic                                rst,
  cr_register_file_if.slave                   wb,
  input  logic                                rsv_valid,
  output logic                                rsv_ready,
  input  logic [CR_FIELDS-1:0]                rsv_enable,
  input  logic [RS_ID_WIDTH-1:0]              rsv_rs_id,
  input  logic                                flush,
  input  logic [1:0][2:0]                     rd_addr,
  output logic [1:0][0:CR_FIELD_BITS-1]       rd_value,
  output logic [1:0]                          rd_busy,
  output logic [1:0][RS_ID_WIDTH-1:0]         rd_tag,
  output logic [0:CR_IMAGE_BITS-1]            cr_out,
  output logic [CR_FIELDS-1:0]                cr_busy_out
);

  logic [CR_FIELDS-1:0][0:CR_FIELD_BITS-1] fld_value;
  logic [CR_FIELDS-1:0]                    fld_busy;
  logic [CR_FIELDS-1:0][RS_ID_WIDTH-1:0]   fld_tag;
  logic                                    rsv_fire;

  assign rsv_ready = !flush;
  assign rsv_fire  = rsv_valid && rsv_ready;

  for (genvar i = 0; i < CR_FIELDS; i++) begin : g_slot
    cr_field_slot #(
      .RS_ID_WIDTH (RS_ID_WIDTH)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .wb_valid   (wb.wb_valid),
      .wb_enable  (wb.wb_enable[i]),
      .wb_rs_id   (wb.wb_rs_id[i]),
      .wb_field   (cr_field_of(wb.wb_result, i)),
      .rsv_fire   (rsv_fire),
      .rsv_enable (rsv_enable[i]),
      .rsv_rs_id  (rsv_rs_id),
      .flush      (flush),
      .fwd_value  (fld_value[i]),
      .fwd_busy   (fld_busy[i]),
      .fwd_tag    (fld_tag[i])
    );

    assign cr_out[CR_FIELD_BITS*i +: CR_FIELD_BITS] = fld_value[i];
  end

  assign cr_busy_out = fld_busy;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_value[p] = fld_value[rd_addr[p]];
      rd_busy[p]  = fld_busy[rd_addr[p]];
      rd_tag[p]   = fld_tag[rd_addr[p]];
    end
  end

endmodule

// File: tb/tb_cr_register_file.sv
// Directed bench for cr_register_file: reservation, retire, stale write-back, flush and reset.
module tb_cr_register_file;
  import cr_register_file_pkg::*;

  localparam int W = 5;

  logic                     clk;
  logic                     rst;
  logic                     rsv_valid;
  logic                     rsv_ready;
  logic [CR_FIELDS-1:0]     rsv_enable;
  logic [W-1:0]             rsv_rs_id;
  logic                     flush;
  logic [1:0][2:0]          rd_addr;
  logic [1:0][0:3]          rd_value;
  logic [1:0]               rd_busy;
  logic [1:0][W-1:0]        rd_tag;
  logic [0:CR_IMAGE_BITS-1] cr_out;
  logic [CR_FIELDS-1:0]     cr_busy_out;

  int checks = 0;
  int errors = 0;

  cr_register_file_if #(.RS_ID_WIDTH(W)) wb_bus ();

  cr_register_file #(.RS_ID_WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb          (wb_bus.slave),
    .rsv_valid   (rsv_valid),
    .rsv_ready   (rsv_ready),
    .rsv_enable  (rsv_enable),
    .rsv_rs_id   (rsv_rs_id),
    .flush       (flush),
    .rd_addr     (rd_addr),
    .rd_value    (rd_value),
    .rd_busy     (rd_busy),
    .rd_tag      (rd_tag),
    .cr_out      (cr_out),
    .cr_busy_out (cr_busy_out)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checker
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drivers
  task automatic drive_idle();
    wb_bus.wb_valid  = 1'b0;
    wb_bus.wb_enable = '0;
    wb_bus.wb_rs_id  = '0;
    wb_bus.wb_result = '0;
    rsv_valid  = 1'b0;
    rsv_enable = '0;
    rsv_rs_id  = '0;
    flush      = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input int fld, input logic [W-1:0] id, input logic [31:0] img);
    wb_bus.wb_valid       = 1'b1;
    wb_bus.wb_enable[fld] = 1'b1;
    wb_bus.wb_rs_id[fld]  = id;
    wb_bus.wb_result      = img;
  endtask

  task automatic drive_rsv(input logic [7:0] en, input logic [W-1:0] id);
    rsv_valid  = 1'b1;
    rsv_enable = en;
    rsv_rs_id  = id;
  endtask

  initial begin
    drive_idle();
    rd_addr = '0;
    rst = 1'b0;
    #3;
    check("reset_cr_out", 64'(cr_out), 64'h0);
    check("reset_busy", 64'(cr_busy_out), 64'h0);
    check("reset_rsv_ready", 64'(rsv_ready), 64'h1);
    check("reset_rd", {rd_value, rd_busy, rd_tag}, 64'h0);
    step();
    step();
    rst = 1'b1;
    step();

    // Reserve field 2 with tag 5; reads this cycle must not see it yet
    rd_addr[0] = 3'd2;
    drive_rsv(8'h04, 5'd5);
    #1;
    check("rsv_cycle_busy", 64'(rd_busy[0]), 64'h0);
    step();
    drive_idle();
    #1;
    check("rsv_busy_vis", 64'(rd_busy[0]), 64'h1);
    check("rsv_tag_vis", 64'(rd_tag[0]), 64'h5);
    check("rsv_busy_vec", 64'(cr_busy_out), 64'h04);

    // Matching write-back forwards in the same cycle
    drive_wb(2, 5'd5, 32'h00A0_0000);
    #1;
    check("fwd_value", 64'(rd_value[0]), 64'hA);
    check("fwd_busy", 64'(rd_busy[0]), 64'h0);
    check("fwd_tag", 64'(rd_tag[0]), 64'h0);
    check("fwd_cr_out", 64'(cr_out), 64'h00A0_0000);
    step();
    drive_idle();
    #1;
    check("wb_cr_out", 64'(cr_out), 64'h00A0_0000);
    check("wb_busy_vec", 64'(cr_busy_out), 64'h00);

    // Stale producer write-back on field 0
    rd_addr[1] = 3'd0;
    drive_rsv(8'h01, 5'd3);
    step();
    drive_idle();
    drive_wb(0, 5'd7, 32'h8000_0000);
    #1;
    check("stale_fwd_value", 64'(rd_value[1]), 64'h0);
    check("stale_fwd_busy", 64'(rd_busy[1]), 64'h1);
    check("stale_fwd_cr", 64'(cr_out), 64'h00A0_0000);
    step();
    drive_idle();
    #1;
    check("stale_value", 64'(rd_value[1]), 64'h0);
    check("stale_busy_tag", {rd_busy[1], 3'b0, rd_tag[1]}, 64'h103);

    // Retire and re-reserve field 1 in the same cycle
    rd_addr[0] = 3'd1;
    drive_rsv(8'h02, 5'd4);
    step();
    drive_idle();
    drive_wb(1, 5'd4, 32'h0200_0000);
    drive_rsv(8'h02, 5'd9);
    #1;
    check("same_cyc_fwd", {rd_value[0], 3'b0, rd_busy[0]}, 64'h20);
    step();
    drive_idle();
    #1;
    check("same_cyc_value", 64'(rd_value[0]), 64'h2);
    check("same_cyc_busy_tag", {rd_busy[0], 3'b0, rd_tag[0]}, 64'h109);
    check("same_cyc_cr", 64'(cr_out), 64'h02A0_0000);
    check("same_cyc_busy_vec", 64'(cr_busy_out), 64'h03);

    // Reserve everything, then flush with a competing reservation and write-backs
    rd_addr[0] = 3'd2;
    drive_rsv(8'hFF, 5'd6);
    step();
    drive_idle();
    #1;
    check("all_busy", 64'(cr_busy_out), 64'hFF);
    check("all_tag", 64'(rd_tag[0]), 64'h6);
    flush = 1'b1;
    drive_rsv(8'hFF, 5'd10);
    drive_wb(5, 5'd6, 32'h0000_0C30);
    drive_wb(6, 5'd7, 32'h0000_0C30);
    #1;
    check("flush_rsv_ready", 64'(rsv_ready), 64'h0);
    check("flush_fwd_busy", 64'(cr_busy_out), 64'hDF);
    check("flush_fwd_cr", 64'(cr_out), 64'h02A0_0C00);
    step();
    drive_idle();
    #1;
    check("flush_busy", 64'(cr_busy_out), 64'h00);
    check("flush_tag", 64'(rd_tag), 64'h0);
    check("flush_cr", 64'(cr_out), 64'h02A0_0C00);
    check("post_flush_ready", 64'(rsv_ready), 64'h1);

    // Field 4 value F, busy with tag 12, then asynchronous reset
    rd_addr[1] = 3'd4;
    drive_wb(4, 5'd0, 32'h0000_F000);
    step();
    drive_idle();
    drive_rsv(8'h10, 5'd12);
    step();
    drive_idle();
    #1;
    check("pre_rst_field4", {rd_value[1], 3'b0, rd_busy[1], 3'b0, rd_tag[1]}, 64'hF10C);
    drive_rsv(8'h10, 5'd13);
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_cr", 64'(cr_out), 64'h0);
    check("async_rst_busy", 64'(cr_busy_out), 64'h0);
    check("async_rst_rd", {rd_value, rd_busy, rd_tag}, 64'h0);
    drive_wb(4, 5'd12, 32'h0000_5000);
    step();
    drive_idle();
    #1;
    check("rst_edge_cr", 64'(cr_out), 64'h0);
    check("rst_edge_busy", 64'(cr_busy_out), 64'h0);
    rst = 1'b1;
    step();
    check("post_rst_ready", 64'(rsv_ready), 64'h1);
    check("post_rst_cr", 64'(cr_out), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
